// File: rtl/mips_core_pkg.sv
// Shared types for the out-of-order back end: physical register tags and
// the issue-queue entry record.
package mips_core_pkg;

    localparam int unsigned IQ_PREG_W    = 6;
    localparam int unsigned IQ_PAYLOAD_W = 64;

    typedef logic [IQ_PREG_W-1:0] PhysReg;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic                    uses_rd;
        PhysReg                  rd_phys;
        logic                    uses_rs;
        PhysReg                  rs_phys;
        logic                    rs_rdy;
        logic                    uses_rt;
        PhysReg                  rt_phys;
        logic                    rt_rdy;
    } IqEntry;

endpackage

// File: rtl/iq_select.sv
// Oldest-ready priority picker: reports the lowest-index set bit of ready.
module iq_select #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 4
) (
    input  logic [DEPTH-1:0] ready,
    output logic             found,
    output logic [IW-1:0]    index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue: slot 0 is oldest, sources wake on
// writeback tag broadcasts, the oldest fully-ready entry issues each cycle.
module issue_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PREG_W    = IQ_PREG_W,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic                         in_uses_rd,
    input  logic [PREG_W-1:0]            in_rd_phys,
    input  logic                         in_uses_rs,
    input  logic [PREG_W-1:0]            in_rs_phys,
    input  logic                         in_rs_rdy,
    input  logic                         in_uses_rt,
    input  logic [PREG_W-1:0]            in_rt_phys,
    input  logic                         in_rt_rdy,
    input  logic                         wb_valid,
    input  logic [PREG_W-1:0]            wb_phys,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic                         out_uses_rd,
    output logic [PREG_W-1:0]            out_rd_phys,
    output logic [PREG_W-1:0]            out_rs_phys,
    output logic [PREG_W-1:0]            out_rt_phys,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    IqEntry          entries      [DEPTH];
    IqEntry          entries_next [DEPTH];
    IqEntry          incoming;
    logic [DEPTH-1:0] ready;
    logic            found;
    logic [IW-1:0]   sel;
    logic            accept;
    logic            fire;
    logic [CW-1:0]   tail;
    logic [CW-1:0]   count_next;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = entries[i].valid & entries[i].rs_rdy & entries[i].rt_rdy;
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_select (
        .ready (ready),
        .found (found),
        .index (sel)
    );

    assign out_valid = found & ~flush;
    assign in_ready  = (count < CW'(DEPTH)) & ~flush;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    assign tail      = fire ? count - CW'(1) : count;

    always_comb begin
        out_payload = '0;
        out_uses_rd = 1'b0;
        out_rd_phys = '0;
        out_rs_phys = '0;
        out_rt_phys = '0;
        if (found) begin
            out_payload = entries[sel].payload;
            out_uses_rd = entries[sel].uses_rd;
            out_rd_phys = entries[sel].rd_phys;
            out_rs_phys = entries[sel].rs_phys;
            out_rt_phys = entries[sel].rt_phys;
        end
    end

    // Unused sources count as ready; a matching broadcast this cycle bypasses into the new entry.
    always_comb begin
        incoming         = '0;
        incoming.valid   = 1'b1;
        incoming.payload = in_payload;
        incoming.uses_rd = in_uses_rd;
        incoming.rd_phys = in_rd_phys;
        incoming.uses_rs = in_uses_rs;
        incoming.rs_phys = in_rs_phys;
        incoming.rs_rdy  = ~in_uses_rs | in_rs_rdy | (wb_valid && wb_phys == in_rs_phys);
        incoming.uses_rt = in_uses_rt;
        incoming.rt_phys = in_rt_phys;
        incoming.rt_rdy  = ~in_uses_rt | in_rt_rdy | (wb_valid && wb_phys == in_rt_phys);
    end

    // Collapse first, then wake the survivors in their new slots, then insert at the tail.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            entries_next[i] = (fire && IW'(i) >= sel) ? entries[i + 1] : entries[i];
        end
        entries_next[DEPTH-1] = fire ? '0 : entries[DEPTH-1];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_valid && entries_next[i].valid) begin
                if (entries_next[i].uses_rs && entries_next[i].rs_phys == wb_phys)
                    entries_next[i].rs_rdy = 1'b1;
                if (entries_next[i].uses_rt && entries_next[i].rt_phys == wb_phys)
                    entries_next[i].rt_rdy = 1'b1;
            end
            if (accept && CW'(i) == tail)
                entries_next[i] = incoming;
        end
    end

    always_comb begin
        count_next = count;
        if (accept && !fire)
            count_next = count + CW'(1);
        else if (fire && !accept)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
            count <= '0;
        end else begin
            entries <= entries_next;
            count   <= count_next;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: vector table for simple cycles, hand
// sequences for ordering/fill/flush, and an issue-order scoreboard.
module tb_issue_queue;

    localparam int DEPTH     = 16;
    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 64;
    localparam int CW        = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_uses_rd;
    logic [PREG_W-1:0]    in_rd_phys;
    logic                 in_uses_rs;
    logic [PREG_W-1:0]    in_rs_phys;
    logic                 in_rs_rdy;
    logic                 in_uses_rt;
    logic [PREG_W-1:0]    in_rt_phys;
    logic                 in_rt_rdy;
    logic                 wb_valid;
    logic [PREG_W-1:0]    wb_phys;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_uses_rd;
    logic [PREG_W-1:0]    out_rd_phys;
    logic [PREG_W-1:0]    out_rs_phys;
    logic [PREG_W-1:0]    out_rt_phys;
    logic [CW-1:0]        count;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH     (DEPTH),
        .PREG_W    (PREG_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_uses_rd  (in_uses_rd),
        .in_rd_phys  (in_rd_phys),
        .in_uses_rs  (in_uses_rs),
        .in_rs_phys  (in_rs_phys),
        .in_rs_rdy   (in_rs_rdy),
        .in_uses_rt  (in_uses_rt),
        .in_rt_phys  (in_rt_phys),
        .in_rt_rdy   (in_rt_rdy),
        .wb_valid    (wb_valid),
        .wb_phys     (wb_phys),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_uses_rd (out_uses_rd),
        .out_rd_phys (out_rd_phys),
        .out_rs_phys (out_rs_phys),
        .out_rt_phys (out_rt_phys),
        .count       (count)
    );

    typedef struct {
        logic [PAYLOAD_W-1:0] payload;
        logic [PREG_W-1:0]    rd;
        logic [PREG_W-1:0]    rs;
        logic [PREG_W-1:0]    rt;
    } exp_t;

    typedef struct {
        logic                 iv;
        logic [PAYLOAD_W-1:0] pl;
        logic [PREG_W-1:0]    rd;
        logic                 urs;
        logic [PREG_W-1:0]    rs;
        logic                 rsr;
        logic                 urt;
        logic [PREG_W-1:0]    rt;
        logic                 rtr;
        logic                 wbv;
        logic [PREG_W-1:0]    wb;
        logic                 ordy;
        logic                 push;
        logic                 e_ov;
        logic [CW-1:0]        e_cnt;
        logic                 e_ir;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   vectors = 0;
    int   errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every issue handshake must match the next expected entry, in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_issue: got payload %0h, expected no issue", out_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_payload", out_payload, e.payload);
                check("issue_rd", 64'(out_rd_phys), 64'(e.rd));
                check("issue_rs", 64'(out_rs_phys), 64'(e.rs));
                check("issue_rt", 64'(out_rt_phys), 64'(e.rt));
            end
        end
    end

    task automatic idle();
        in_valid   = 1'b0;
        in_payload = '0;
        in_uses_rd = 1'b0;
        in_rd_phys = '0;
        in_uses_rs = 1'b0;
        in_rs_phys = '0;
        in_rs_rdy  = 1'b0;
        in_uses_rt = 1'b0;
        in_rt_phys = '0;
        in_rt_rdy  = 1'b0;
        wb_valid   = 1'b0;
        wb_phys    = '0;
        flush      = 1'b0;
    endtask

    task automatic insert(input logic [PAYLOAD_W-1:0] pl, input logic [PREG_W-1:0] rd,
                          input logic [PREG_W-1:0] rs, input logic rsr,
                          input logic [PREG_W-1:0] rt, input logic rtr);
        in_valid   = 1'b1;
        in_payload = pl;
        in_uses_rd = 1'b1;
        in_rd_phys = rd;
        in_uses_rs = 1'b1;
        in_rs_phys = rs;
        in_rs_rdy  = rsr;
        in_uses_rt = 1'b1;
        in_rt_phys = rt;
        in_rt_rdy  = rtr;
    endtask

    task automatic push(input logic [PAYLOAD_W-1:0] pl, input logic [PREG_W-1:0] rd,
                        input logic [PREG_W-1:0] rs, input logic [PREG_W-1:0] rt);
        exp_t e;
        e.payload = pl;
        e.rd      = rd;
        e.rs      = rs;
        e.rt      = rt;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        idle();
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (count == 0) break;
            next_cycle();
        end
        check(name, 64'(count), 64'd0);
        next_cycle();
    endtask

    initial begin
        // Table: idle cycles after reset, insert-to-issue latency, unused-source-ready, insert bypass.
        for (int i = 0; i < 5; i++)
            tbl[i] = '{0, 64'h0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 5'd0, 1};
        tbl[5]  = '{1, 64'hA0A0, 6'd33, 1, 6'd5, 1, 1, 6'd6, 1, 0, 6'd0, 1, 1, 0, 5'd0, 1};
        tbl[6]  = '{0, 64'h0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd0, 1, 0, 1, 5'd1, 1};
        tbl[7]  = '{0, 64'h0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd0, 1, 0, 0, 5'd0, 1};
        tbl[8]  = '{1, 64'hD0D0, 6'd12, 0, 6'd0, 0, 1, 6'd41, 0, 1, 6'd41, 1, 1, 0, 5'd0, 1};
        tbl[9]  = '{0, 64'h0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd0, 1, 0, 1, 5'd1, 1};
        tbl[10] = '{0, 64'h0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd0, 1, 0, 0, 5'd0, 1};

        idle();
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_count", 64'(count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_rd", 64'(out_rd_phys), 64'd0);
        next_cycle();

        for (int v = 0; v < 11; v++) begin
            in_valid   = tbl[v].iv;
            in_payload = tbl[v].pl;
            in_uses_rd = tbl[v].iv;
            in_rd_phys = tbl[v].rd;
            in_uses_rs = tbl[v].urs;
            in_rs_phys = tbl[v].rs;
            in_rs_rdy  = tbl[v].rsr;
            in_uses_rt = tbl[v].urt;
            in_rt_phys = tbl[v].rt;
            in_rt_rdy  = tbl[v].rtr;
            wb_valid   = tbl[v].wbv;
            wb_phys    = tbl[v].wb;
            out_ready  = tbl[v].ordy;
            if (tbl[v].push) push(tbl[v].pl, tbl[v].rd, tbl[v].rs, tbl[v].rt);
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].e_ov));
            check($sformatf("vec%0d_count", v), 64'(count), 64'(tbl[v].e_cnt));
            check($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'(tbl[v].e_ir));
            next_cycle();
        end
        idle();

        // Younger ready C overtakes older B; B issues one cycle after its wakeup edge.
        out_ready = 1'b1;
        insert(64'hB0B0, 6'd10, 6'd40, 1'b0, 6'd7, 1'b1);
        @(negedge clk);
        check("c3_empty_ov", 64'(out_valid), 64'd0);
        next_cycle();
        insert(64'hC0C0, 6'd11, 6'd8, 1'b1, 6'd9, 1'b1);
        push(64'hC0C0, 6'd11, 6'd8, 6'd9);
        @(negedge clk);
        check("c3_b_blocked", 64'(out_valid), 64'd0);
        check("c3_count1", 64'(count), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("c3_c_issues", 64'(out_valid), 64'd1);
        check("c3_count2", 64'(count), 64'd2);
        next_cycle();
        wb_valid = 1'b1;
        wb_phys  = 6'd40;
        @(negedge clk);
        check("c3_no_same_cycle_issue", 64'(out_valid), 64'd0);
        next_cycle();
        idle();
        push(64'hB0B0, 6'd10, 6'd40, 6'd7);
        @(negedge clk);
        check("c3_b_issues", 64'(out_valid), 64'd1);
        next_cycle();
        @(negedge clk);
        check("c3_empty", 64'(count), 64'd0);
        next_cycle();

        // Fill to DEPTH with issue stalled, then overflow and simultaneous accept/fire.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            insert(64'h500 + 64'(i), 6'(i), 6'(i + 16), 1'b1, 6'(i + 32), 1'b1);
            push(64'h500 + 64'(i), 6'(i), 6'(i + 16), 6'(i + 32));
            next_cycle();
        end
        insert(64'h999, 6'd63, 6'd1, 1'b1, 6'd2, 1'b1);
        @(negedge clk);
        check("c5_full_count", 64'(count), 64'd16);
        check("c5_full_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("c5_17th_ignored", 64'(count), 64'd16);
        next_cycle();
        insert(64'h600, 6'd50, 6'd51, 1'b1, 6'd52, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("c5_fire_full_count", 64'(count), 64'd16);
        check("c5_fire_full_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        push(64'h600, 6'd50, 6'd51, 6'd52);
        @(negedge clk);
        check("c5_after_fire_count", 64'(count), 64'd15);
        check("c5_after_fire_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("c5_accept_fire_count", 64'(count), 64'd15);
        next_cycle();
        drain("c5_drain");

        // Flush dominates accept, fire and wakeup.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            insert(64'h700 + 64'(i), 6'(i), 6'd50, 1'b1, 6'd51, 1'b0);
            if (i == 4) in_rt_rdy = 1'b1;
            next_cycle();
        end
        insert(64'h777, 6'd20, 6'd21, 1'b1, 6'd22, 1'b1);
        wb_valid  = 1'b1;
        wb_phys   = 6'd51;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("c6_flush_ov", 64'(out_valid), 64'd0);
        check("c6_flush_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("c6_post_count", 64'(count), 64'd0);
        check("c6_post_ov", 64'(out_valid), 64'd0);
        next_cycle();
        insert(64'h880, 6'd30, 6'd31, 1'b1, 6'd32, 1'b1);
        push(64'h880, 6'd30, 6'd31, 6'd32);
        next_cycle();
        insert(64'h881, 6'd33, 6'd34, 1'b1, 6'd35, 1'b1);
        push(64'h881, 6'd33, 6'd34, 6'd35);
        next_cycle();
        drain("c6_drain");

        // Reset mid-operation drops entries without issuing.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            insert(64'h900 + 64'(i), 6'(i), 6'd1, 1'b1, 6'd2, 1'b1);
            next_cycle();
        end
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_ov", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        out_ready = 1'b1;
        repeat (3) next_cycle();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
